feature_frame_sequencer: RTL and testbench

Parametrised successor to the single-frame feature shift register. It sequences SAR conversions across up to NUM_FEAT feature slots and captures each N-bit quantised result into an addressed slot. Completed frames go to a double-buffered output with a valid/ready handshake. It sits between the SAR ADC front end and the classifier input, and adds runtime feature count, single-shot/continuous modes, abort and overrun detection.

---
 rtl/feature_frame_sequencer_if.sv | 37 +++
 rtl/feature_frame_sequencer.sv | 142 ++++++++++++++
 tb/tb_feature_frame_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/feature_frame_sequencer_if.sv
// Bundles the sequencer's control, SAR data and frame-handshake signals.
// master drives the sequencer (front end / classifier side); slave is the sequencer.
interface feature_frame_sequencer_if #(
    parameter int N          = 4,
    parameter int SAR_CYCLES = 5,
    parameter int NUM_FEAT   = 10
);
    localparam int FW  = $clog2(NUM_FEAT);
    localparam int SCW = $clog2(SAR_CYCLES);

    logic                  start;
    logic                  abort;
    logic                  mode_cont;
    logic [FW-1:0]         last_feat;
    logic [N-1:0]          quant_feat;
    logic                  frame_ready;
    logic                  clr_overrun;
    logic                  busy;
    logic [SCW-1:0]        sar_cnt;
    logic [NUM_FEAT-1:0]   feat_sel;
    logic [NUM_FEAT*N-1:0] frame_data;
    logic                  frame_valid;
    logic                  overrun;
    logic                  state_dbg;

    // A frame moves downstream on any clock where frame_valid and frame_ready are both 1;
    // frame_valid never drops without that transfer.
    modport master (
        output start, abort, mode_cont, last_feat, quant_feat, frame_ready, clr_overrun,
        input  busy, sar_cnt, feat_sel, frame_data, frame_valid, overrun, state_dbg
    );

    modport slave (
        input  start, abort, mode_cont, last_feat, quant_feat, frame_ready, clr_overrun,
        output busy, sar_cnt, feat_sel, frame_data, frame_valid, overrun, state_dbg
    );
endinterface

// File: rtl/feature_frame_sequencer.sv
// Sequences SAR conversions over a runtime-sized set of feature slots and hands
// completed frames to a double-buffered valid/ready output with overrun detection.
module feature_frame_sequencer #(
    parameter int N          = 4,
    parameter int SAR_CYCLES = 5,
    parameter int NUM_FEAT   = 10
) (
    input logic                      clk,
    input logic                      rst,
    feature_frame_sequencer_if.slave bus
);
    localparam int FW  = $clog2(NUM_FEAT);
    localparam int SCW = $clog2(SAR_CYCLES);
    localparam int DW  = NUM_FEAT * N;
    localparam logic [FW-1:0]  LF_MAX   = FW'(NUM_FEAT - 1);
    localparam logic [SCW-1:0] SAR_LAST = SCW'(SAR_CYCLES - 1);

    typedef enum logic {S_IDLE = 1'b0, S_CONV = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [SCW-1:0]      r_sar_cnt;
    logic [FW-1:0]       r_feat_cnt;
    logic [FW-1:0]       r_lf;
    logic [DW-1:0]       r_work;
    logic [DW-1:0]       r_frame_data;
    logic                r_frame_valid;
    logic                r_overrun;

    logic                w_start_acc;
    logic                w_slot_end;
    logic                w_frame_done;
    logic                w_load;
    logic                w_drop;
    logic [FW-1:0]       w_lf_clamped;
    logic [DW-1:0]       w_work_wr;
    logic [NUM_FEAT-1:0] w_feat_onehot;

    assign w_lf_clamped = (bus.last_feat > LF_MAX) ? LF_MAX : bus.last_feat;

    // Merge the slot captured this cycle so a completing frame already contains it.
    always_comb begin
        w_work_wr     = r_work;
        w_feat_onehot = '0;
        for (int k = 0; k < NUM_FEAT; k++) begin
            if (r_feat_cnt == FW'(k)) begin
                w_work_wr[k*N +: N] = bus.quant_feat;
                w_feat_onehot[k]    = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_acc  = 1'b0;
        w_slot_end   = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.abort && bus.start) begin
                    w_start_acc  = 1'b1;
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                w_slot_end = (r_sar_cnt == SAR_LAST);
                if (bus.abort) begin
                    w_state_next = S_IDLE;
                end else if (w_slot_end && (r_feat_cnt >= r_lf)) begin
                    w_frame_done = 1'b1;
                    if (!bus.mode_cont) w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_load = w_frame_done && (!r_frame_valid || bus.frame_ready);
    assign w_drop = w_frame_done && r_frame_valid && !bus.frame_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sar_cnt  <= '0;
            r_feat_cnt <= '0;
            r_lf       <= '0;
            r_work     <= '0;
        end else if (w_start_acc) begin
            r_sar_cnt  <= '0;
            r_feat_cnt <= '0;
            r_lf       <= w_lf_clamped;
            r_work     <= '0;
        end else if (r_state == S_CONV) begin
            if (bus.abort) begin
                r_sar_cnt  <= '0;
                r_feat_cnt <= '0;
            end else if (w_slot_end) begin
                r_sar_cnt <= '0;
                if (w_frame_done) begin
                    // Prepare the next continuous frame; harmless when going idle.
                    r_feat_cnt <= '0;
                    r_work     <= '0;
                    r_lf       <= w_lf_clamped;
                end else begin
                    r_feat_cnt <= r_feat_cnt + 1'b1;
                    r_work     <= w_work_wr;
                end
            end else begin
                r_sar_cnt <= r_sar_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_load) begin
                r_frame_data  <= w_work_wr;
                r_frame_valid <= 1'b1;
            end else if (r_frame_valid && bus.frame_ready) begin
                r_frame_valid <= 1'b0;
            end
            if (w_drop)                r_overrun <= 1'b1;
            else if (bus.clr_overrun)  r_overrun <= 1'b0;
        end
    end

    assign bus.busy        = (r_state == S_CONV);
    assign bus.sar_cnt     = r_sar_cnt;
    assign bus.feat_sel    = (r_state == S_CONV) ? w_feat_onehot : '0;
    assign bus.frame_data  = r_frame_data;
    assign bus.frame_valid = r_frame_valid;
    assign bus.overrun     = r_overrun;
    assign bus.state_dbg   = r_state;
endmodule

// File: tb/tb_feature_frame_sequencer.sv
// Bench for feature_frame_sequencer: frame vectors, directed corner sequences and
// random traffic checked against an elapsed-time reference model.
module tb_feature_frame_sequencer;
    localparam int N   = 4;
    localparam int SAR = 5;
    localparam int NF  = 10;
    localparam int FW  = $clog2(NF);
    localparam int DW  = NF * N;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    feature_frame_sequencer_if #(.N(N), .SAR_CYCLES(SAR), .NUM_FEAT(NF)) ffs_if ();

    feature_frame_sequencer #(.N(N), .SAR_CYCLES(SAR), .NUM_FEAT(NF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ffs_if)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a frame is "elapsed cycles since frame start"; slot = elapsed / SAR.
    bit            m_active;
    int            m_elapsed;
    int            m_lf;
    logic [N-1:0]  m_buf [NF];
    logic [DW-1:0] m_out;
    bit            m_valid;
    bit            m_overrun;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [FW-1:0] lf;
        logic [N-1:0]  base;
        int            exp_cycles;
        logic [DW-1:0] exp_data;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        return (v > NF - 1) ? NF - 1 : v;
    endfunction

    function automatic logic [DW-1:0] pack_buf();
        logic [DW-1:0] p = '0;
        for (int k = 0; k < NF; k++) p[k*N +: N] = m_buf[k];
        return p;
    endfunction

    task automatic model_reset();
        m_active = 0; m_elapsed = 0; m_lf = 0; m_out = '0; m_valid = 0; m_overrun = 0;
        foreach (m_buf[k]) m_buf[k] = '0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        bit loaded = 0;
        bit dropped = 0;
        bit xfer;
        int slot;
        xfer = m_valid && ffs_if.frame_ready;
        if (!m_active) begin
            if (!ffs_if.abort && ffs_if.start) begin
                m_active = 1; m_elapsed = 0; m_lf = clamp(int'(ffs_if.last_feat));
                foreach (m_buf[k]) m_buf[k] = '0;
            end
        end else if (ffs_if.abort) begin
            m_active = 0; m_elapsed = 0;
        end else if (m_elapsed % SAR == SAR - 1) begin
            slot = m_elapsed / SAR;
            m_buf[slot] = ffs_if.quant_feat;
            if (slot < m_lf) begin
                m_elapsed++;
            end else begin
                if (!m_valid || ffs_if.frame_ready) begin
                    m_out = pack_buf(); m_valid = 1; exp_q.push_back(m_out); loaded = 1;
                end else begin
                    m_overrun = 1; dropped = 1;
                end
                m_elapsed = 0; m_lf = clamp(int'(ffs_if.last_feat));
                foreach (m_buf[k]) m_buf[k] = '0;
                if (!ffs_if.mode_cont) m_active = 0;
            end
        end else begin
            m_elapsed++;
        end
        if (xfer && !loaded) m_valid = 0;
        if (ffs_if.clr_overrun && !dropped) m_overrun = 0;
    endtask

    task automatic check_outputs();
        check("busy", ffs_if.busy, m_active);
        check("sar_cnt", ffs_if.sar_cnt, m_active ? m_elapsed % SAR : 0);
        check("feat_sel", ffs_if.feat_sel, m_active ? (64'd1 << (m_elapsed / SAR)) : 64'd0);
        check("frame_valid", ffs_if.frame_valid, m_valid);
        check("frame_data", ffs_if.frame_data, m_out);
        check("overrun", ffs_if.overrun, m_overrun);
    endtask

    // One clock: scoreboard on transfer, model update at the edge, output check on the negedge.
    task automatic step();
        if (m_valid && ffs_if.frame_ready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_frame: queue empty, frame_data %0h", ffs_if.frame_data);
            end else begin
                check("sb_frame", ffs_if.frame_data, exp_q.pop_front());
            end
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        ffs_if.start = 0; ffs_if.abort = 0; ffs_if.mode_cont = 0; ffs_if.last_feat = '0;
        ffs_if.quant_feat = '0; ffs_if.frame_ready = 0; ffs_if.clr_overrun = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_start(input logic [FW-1:0] lf, input logic cont);
        ffs_if.start = 1; ffs_if.last_feat = lf; ffs_if.mode_cont = cont;
        step();
        ffs_if.start = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int n = 0;
        drive_start(v.lf, 1'b0);
        while (!ffs_if.frame_valid && n < 200) begin
            ffs_if.quant_feat = N'(int'(v.base) + n / SAR);
            step();
            n++;
        end
        check("vec_cycles", n, v.exp_cycles);
        check("vec_data", ffs_if.frame_data, v.exp_data);
        check("vec_busy", ffs_if.busy, 0);
        ffs_if.frame_ready = 1;
        step();
        ffs_if.frame_ready = 0;
    endtask

    initial begin
        vecs[0] = '{lf: 4'd2,  base: 4'h1, exp_cycles: 15, exp_data: 40'h0000000321};
        vecs[1] = '{lf: 4'd15, base: 4'h1, exp_cycles: 50, exp_data: 40'hA987654321};
        vecs[2] = '{lf: 4'd0,  base: 4'h7, exp_cycles: 5,  exp_data: 40'h0000000007};
        vecs[3] = '{lf: 4'd4,  base: 4'hC, exp_cycles: 25, exp_data: 40'h00000FEDC};
        vecs[4] = '{lf: 4'd9,  base: 4'h5, exp_cycles: 50, exp_data: 40'hEDCBA98765};

        idle_inputs();
        @(negedge clk);
        #2;
        do_reset();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Continuous, full frames, downstream always ready.
        ffs_if.frame_ready = 1;
        drive_start(4'd9, 1'b1);
        for (int n = 0; n < 150; n++) begin
            ffs_if.quant_feat = N'($urandom_range(0, 15));
            step();
            if (n == 48) check("cont_not_yet", ffs_if.frame_valid, 0);
            if (n == 49 || n == 99 || n == 149) begin
                check("cont_valid", ffs_if.frame_valid, 1);
                check("cont_overrun", ffs_if.overrun, 0);
            end
        end
        ffs_if.abort = 1; step(); ffs_if.abort = 0;
        step();
        ffs_if.frame_ready = 0;

        // Continuous one-slot frames with no consumer: overrun and clear priority.
        drive_start(4'd0, 1'b1);
        for (int n = 0; n < 15; n++) begin
            ffs_if.quant_feat = N'(n + 3);
            ffs_if.clr_overrun = (n == 10 || n == 14);
            step();
            if (n == 4)  check("ovr_first", ffs_if.frame_data, 40'h7);
            if (n == 9)  check("ovr_set", ffs_if.overrun, 1);
            if (n == 10) check("ovr_clr", ffs_if.overrun, 0);
            if (n == 14) check("ovr_set_wins", ffs_if.overrun, 1);
        end
        ffs_if.clr_overrun = 0;
        ffs_if.abort = 1; step(); ffs_if.abort = 0;

        // Abort in the middle of a frame while a previous frame is still held.
        drive_start(4'd9, 1'b0);
        for (int n = 0; n < 20; n++) begin
            ffs_if.quant_feat = N'($urandom_range(0, 15));
            step();
        end
        check("abort_at_slot4", ffs_if.feat_sel, 10'h010);
        ffs_if.abort = 1; step(); ffs_if.abort = 0;
        check("abort_busy", ffs_if.busy, 0);
        check("abort_feat_sel", ffs_if.feat_sel, 0);
        check("abort_hold_data", ffs_if.frame_data, 40'h7);
        check("abort_hold_valid", ffs_if.frame_valid, 1);

        // Clamped last_feat; ready pulsed exactly on the completion cycle.
        drive_start(4'd15, 1'b0);
        for (int n = 0; n < 50; n++) begin
            ffs_if.quant_feat = N'(1 + n / SAR);
            ffs_if.frame_ready = (n == 49);
            step();
        end
        ffs_if.frame_ready = 0;
        check("swap_valid", ffs_if.frame_valid, 1);
        check("swap_data", ffs_if.frame_data, 40'hA987654321);
        check("swap_busy", ffs_if.busy, 0);

        // Asynchronous reset mid-frame, then the first-frame timing again.
        drive_start(4'd2, 1'b0);
        for (int n = 0; n < 7; n++) step();
        #2;
        do_reset();
        check("rst_data_zero", ffs_if.frame_data, 0);
        run_vec(vecs[0]);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            ffs_if.start       = ($urandom_range(0, 9) == 0);
            ffs_if.abort       = ($urandom_range(0, 39) == 0);
            ffs_if.mode_cont   = $urandom_range(0, 1);
            ffs_if.last_feat   = FW'($urandom_range(0, 15));
            ffs_if.quant_feat  = N'($urandom_range(0, 15));
            ffs_if.frame_ready = ($urandom_range(0, 2) != 0);
            ffs_if.clr_overrun = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
